// File: rtl/module_pipe_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle mul/div, memory-busy stalls and jump flushes.
// Zero-cycle (Mealy) flag_hold/flag_flush; mem_busy_i holds every stage and defers any jump flush.
module module_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_arst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_jump_req,
  input  logic             ex_mdiv_start,
  input  logic             mdiv_done,
  input  logic             mem_busy_i,
  input  logic             cnt_clr_i,
  output logic             flag_flush,
  output logic [2:0]       flag_hold,
  output logic [1:0]       ctrl_state_o,
  output logic             jump_pend_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_MDIV_WAIT = 2'b01
  } state_t;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_LU   = 3'b001;
  localparam logic [2:0] HOLD_EX   = 3'b010;
  localparam logic [2:0] HOLD_MEM  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             jump_pend_q, jump_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             in_run;
  logic             load_use;
  logic [2:0]       hold;
  logic             flush;

  assign in_run = (state_q == ST_RUN);

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // First matching rule wins; a jump seen under mem_busy_i is remembered and
  // flushed on the first cycle the memory lets the pipe advance.
  always_comb begin
    hold        = HOLD_NONE;
    flush       = 1'b0;
    state_d     = state_q;
    jump_pend_d = jump_pend_q;

    if (mem_busy_i) begin
      hold = HOLD_MEM;
      if (ex_jump_req && in_run) begin
        jump_pend_d = 1'b1;
      end
    end else if (!in_run && !mdiv_done) begin
      hold = HOLD_EX;
    end else if ((ex_jump_req && in_run) || jump_pend_q) begin
      flush       = 1'b1;
      jump_pend_d = 1'b0;
    end else if (in_run && ex_mdiv_start) begin
      hold    = HOLD_EX;
      state_d = ST_MDIV_WAIT;
    end else if (load_use) begin
      hold = HOLD_LU;
    end

    if (!in_run && mdiv_done && !mem_busy_i) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((hold != HOLD_NONE) && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) begin
      state_q     <= ST_RUN;
      jump_pend_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      jump_pend_q <= jump_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Flags are quiet during reset even though the inputs may still be active.
  assign flag_hold    = sys_arst ? HOLD_NONE : hold;
  assign flag_flush   = sys_arst ? 1'b0 : flush;
  assign ctrl_state_o = state_q;
  assign jump_pend_o  = jump_pend_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_module_pipe_ctrl.sv
// Scoreboard bench for module_pipe_ctrl with 4-bit counters.
module tb_module_pipe_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_arst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_jump_req;
  logic       ex_mdiv_start, mdiv_done, mem_busy_i, cnt_clr_i;
  logic       flag_flush;
  logic [2:0] flag_hold;
  logic [1:0] ctrl_state_o;
  logic       jump_pend_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  typedef struct {
    string tag;
    int    hold;
    int    flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  module_pipe_ctrl #(.CNT_W(4)) dut (
    .sys_clk       (sys_clk),
    .sys_arst      (sys_arst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_jump_req   (ex_jump_req),
    .ex_mdiv_start (ex_mdiv_start),
    .mdiv_done     (mdiv_done),
    .mem_busy_i    (mem_busy_i),
    .cnt_clr_i     (cnt_clr_i),
    .flag_flush    (flag_flush),
    .flag_hold     (flag_hold),
    .ctrl_state_o  (ctrl_state_o),
    .jump_pend_o   (jump_pend_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_jump_req = 1'b0; ex_mdiv_start = 1'b0; mdiv_done = 1'b0;
    mem_busy_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  // Inputs are set at a falling edge; flags are checked 1ns later, then the
  // task returns on the next falling edge, after the state update.
  task automatic cyc(input string tag, input int eh, input int ef);
    exp_t e;
    sb_q.push_back('{tag, eh, ef});
    #1;
    e = sb_q.pop_front();
    chk($sformatf("%s_hold", e.tag), int'(flag_hold), e.hold);
    chk($sformatf("%s_flush", e.tag), int'(flag_flush), e.flush);
    @(negedge sys_clk);
  endtask

  task automatic chk_regs(input string tag, input int st, input int pend,
                          input int scnt, input int fcnt);
    chk($sformatf("%s_state", tag), int'(ctrl_state_o), st);
    chk($sformatf("%s_pend", tag), int'(jump_pend_o), pend);
    chk($sformatf("%s_stall", tag), int'(stall_cnt_o), scnt);
    chk($sformatf("%s_flushcnt", tag), int'(flush_cnt_o), fcnt);
  endtask

  task automatic clr();
    idle();
    cnt_clr_i = 1'b1;
    cyc("clr", 0, 0);
    cnt_clr_i = 1'b0;
  endtask

  initial begin
    idle();
    sys_arst = 1'b1;
    mem_busy_i = 1'b1;
    ex_jump_req = 1'b1;
    @(negedge sys_clk);
    cyc("rst", 0, 0);
    chk_regs("rst", 0, 0, 0, 0);
    sys_arst = 1'b0;
    idle();
    @(negedge sys_clk);

    // Load-use detection
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2_used = 1'b1; id_rs2 = 5'd5;
    cyc("lu_rs2", 1, 0);
    ex_rd = 5'd0;
    cyc("lu_rd0", 0, 0);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    cyc("lu_rs1", 1, 0);
    id_rs1_used = 1'b0;
    cyc("lu_unused", 0, 0);
    idle(); ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    cyc("no_load", 0, 0);
    chk_regs("lu", 0, 0, 2, 0);
    clr();
    chk_regs("clr", 0, 0, 0, 0);

    // Mul/div wait
    idle(); mdiv_done = 1'b1;
    cyc("done_in_run", 0, 0);
    chk_regs("done_in_run", 0, 0, 0, 0);
    idle(); ex_mdiv_start = 1'b1;
    cyc("md_start", 2, 0);
    chk_regs("md_start", 1, 0, 1, 0);
    idle();
    cyc("md_w1", 2, 0);
    ex_jump_req = 1'b1;
    cyc("md_w2_jmp", 2, 0);
    idle();
    cyc("md_w3", 2, 0);
    chk_regs("md_w3", 1, 0, 4, 0);
    mdiv_done = 1'b1; ex_jump_req = 1'b1;
    cyc("md_done", 0, 0);
    chk_regs("md_done", 0, 0, 4, 0);

    // Jump outranks mul/div start
    clr();
    ex_jump_req = 1'b1; ex_mdiv_start = 1'b1;
    cyc("jmp_over_md", 0, 1);
    chk_regs("jmp_over_md", 0, 0, 0, 1);

    // Deferred jump under memory busy
    clr();
    mem_busy_i = 1'b1; ex_jump_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("dj_busy", 4, 0);
    chk_regs("dj_busy", 0, 1, 3, 0);
    idle();
    cyc("dj_flush", 0, 1);
    chk_regs("dj_flush", 0, 0, 3, 1);
    cyc("dj_after", 0, 0);
    mem_busy_i = 1'b1; ex_jump_req = 1'b1;
    cyc("dj2_busy", 4, 0);
    mem_busy_i = 1'b0;
    cyc("dj2_flush", 0, 1);
    idle();
    cyc("dj2_after", 0, 0);
    chk_regs("dj2", 0, 0, 4, 2);

    // Memory busy outranks mul/div completion
    clr();
    ex_mdiv_start = 1'b1;
    cyc("p_start", 2, 0);
    idle(); mem_busy_i = 1'b1; mdiv_done = 1'b1;
    cyc("p_busy1", 4, 0);
    cyc("p_busy2", 4, 0);
    chk_regs("p_busy", 1, 0, 3, 0);
    mem_busy_i = 1'b0;
    cyc("p_done", 0, 0);
    chk_regs("p_done", 0, 0, 3, 0);

    // Counter saturation and clear
    clr();
    mem_busy_i = 1'b1;
    for (int i = 0; i < 20; i++) cyc("sat", 4, 0);
    chk_regs("sat", 0, 0, 15, 0);
    cnt_clr_i = 1'b1;
    cyc("sat_clr", 4, 0);
    chk_regs("sat_clr", 0, 0, 0, 0);
    idle(); ex_jump_req = 1'b1;
    for (int i = 0; i < 17; i++) cyc("fsat", 0, 1);
    chk_regs("fsat", 0, 0, 0, 15);

    // Reset during mul/div wait
    clr();
    ex_mdiv_start = 1'b1;
    cyc("r_start", 2, 0);
    idle();
    cyc("r_wait", 2, 0);
    chk_regs("r_wait", 1, 0, 2, 0);
    mem_busy_i = 1'b1; sys_arst = 1'b1;
    cyc("r_arst", 0, 0);
    chk_regs("r_arst", 0, 0, 0, 0);
    sys_arst = 1'b0; idle();
    cyc("r_rel", 0, 0);
    chk_regs("r_rel", 0, 0, 0, 0);

    // Reset with a pending jump
    mem_busy_i = 1'b1; ex_jump_req = 1'b1;
    cyc("rp_busy", 4, 0);
    chk_regs("rp_busy", 0, 1, 1, 0);
    idle(); sys_arst = 1'b1;
    cyc("rp_arst", 0, 0);
    sys_arst = 1'b0;
    cyc("rp_rel", 0, 0);
    chk_regs("rp_rel", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
